// File: rtl/dp_ctrl_pkg.sv
// Shared types and constants for the data-processing sequencer: state codes,
// ARM condition codes, flag bit positions and the strobe bundle.
package dp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Writing rd=15 in WB is an exception return through the PC.
  localparam logic [3:0] RD_PC = 4'hF;

  typedef struct packed {
    logic mem_req;
    logic ir_we;
    logic pc_we;
    logic pc_src;
    logic rf_re;
    logic alu_en;
    logic flag_we;
    logic rf_we;
    logic und_trap;
  } strobe_t;

  function automatic logic state_is_busy(input state_e st);
    return (st == ST_FETCH) || (st == ST_DECODE) || (st == ST_EXEC) || (st == ST_WB);
  endfunction

endpackage

// File: rtl/dp_seq_ctrl_cond_check.sv
// Combinational evaluation of the instruction condition field against NZCV.
module cond_check
  import dp_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  assign n = nzcv_i[FLAG_N];
  assign z = nzcv_i[FLAG_Z];
  assign c = nzcv_i[FLAG_C];
  assign v = nzcv_i[FLAG_V];

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the data-processing datapath.
// Strobes are decoded combinationally from the state register and decoder inputs.
module dp_seq_ctrl
  import dp_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mem_rdy,
  input  logic [31:0] ir,
  input  logic        und_ins,
  input  logic        ttcc,
  input  logic        s,
  input  logic [3:0]  rd,
  input  logic [3:0]  nzcv,
  output logic        mem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        rf_re,
  output logic        alu_en,
  output logic        flag_we,
  output logic        rf_we,
  output logic        und_trap,
  output logic        busy,
  output logic [2:0]  state,
  output logic [31:0] retire_cnt
);

  state_e      state_q, state_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  strobe_t     strb;
  logic        cond_pass;
  state_e      boundary_st;

  // Only the condition field is interpreted here; the rest goes to the decoder.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[27:0];

  cond_check u_cond_check (
    .cond_i (ir[31:28]),
    .nzcv_i (nzcv),
    .pass_o (cond_pass)
  );

  // run is honoured only at an instruction boundary.
  assign boundary_st = run ? ST_FETCH : ST_IDLE;

  always_comb begin
    state_d = state_q;
    strb    = '0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        strb.mem_req = 1'b1;
        if (mem_rdy) begin
          strb.ir_we = 1'b1;
          strb.pc_we = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        strb.rf_re = 1'b1;
        if (und_ins)         state_d = ST_TRAP;
        else if (!cond_pass) state_d = boundary_st;
        else                 state_d = ST_EXEC;
      end
      ST_EXEC: begin
        strb.alu_en  = 1'b1;
        strb.flag_we = s | ttcc;
        state_d      = ttcc ? boundary_st : ST_WB;
      end
      ST_WB: begin
        if (rd == RD_PC) begin
          strb.pc_we  = 1'b1;
          strb.pc_src = 1'b1;
        end else begin
          strb.rf_we = 1'b1;
        end
        state_d = boundary_st;
      end
      ST_TRAP: begin
        strb.und_trap = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign retire_cnt_d = (state_q == ST_EXEC) ? retire_cnt_q + 32'd1 : retire_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign mem_req    = strb.mem_req;
  assign ir_we      = strb.ir_we;
  assign pc_we      = strb.pc_we;
  assign pc_src     = strb.pc_src;
  assign rf_re      = strb.rf_re;
  assign alu_en     = strb.alu_en;
  assign flag_we    = strb.flag_we;
  assign rf_we      = strb.rf_we;
  assign und_trap   = strb.und_trap;
  assign busy       = state_is_busy(state_q);
  assign state      = state_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// Directed bench for dp_seq_ctrl: per-cycle state/strobe tables and retire counts.
module tb_dp_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic        mem_rdy;
  logic [31:0] ir;
  logic        und_ins;
  logic        ttcc;
  logic        s;
  logic [3:0]  rd;
  logic [3:0]  nzcv;
  logic        mem_req, ir_we, pc_we, pc_src, rf_re, alu_en, flag_we, rf_we, und_trap, busy;
  logic [2:0]  state;
  logic [31:0] retire_cnt;

  int errors = 0;
  int checks = 0;

  // {mem_req, ir_we, pc_we, pc_src, rf_re, alu_en, flag_we, rf_we, und_trap, busy}
  logic [9:0] strb;
  assign strb = {mem_req, ir_we, pc_we, pc_src, rf_re, alu_en, flag_we, rf_we, und_trap, busy};

  localparam logic [9:0] S_IDLE = 10'b0000000000;
  localparam logic [9:0] S_FW   = 10'b1000000001;
  localparam logic [9:0] S_FR   = 10'b1110000001;
  localparam logic [9:0] S_DEC  = 10'b0000100001;
  localparam logic [9:0] S_EX   = 10'b0000010001;
  localparam logic [9:0] S_EXF  = 10'b0000011001;
  localparam logic [9:0] S_WB   = 10'b0000000101;
  localparam logic [9:0] S_WBPC = 10'b0011000001;
  localparam logic [9:0] S_TRAP = 10'b0000000010;

  dp_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mem_rdy    (mem_rdy),
    .ir         (ir),
    .und_ins    (und_ins),
    .ttcc       (ttcc),
    .s          (s),
    .rd         (rd),
    .nzcv       (nzcv),
    .mem_req    (mem_req),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .rf_re      (rf_re),
    .alu_en     (alu_en),
    .flag_we    (flag_we),
    .rf_we      (rf_we),
    .und_trap   (und_trap),
    .busy       (busy),
    .state      (state),
    .retire_cnt (retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_instr(input logic [31:0] w, input logic u, input logic t,
                           input logic sb, input logic [3:0] d);
    ir = w; und_ins = u; ttcc = t; s = sb; rd = d;
  endtask

  // Leaves the DUT in IDLE at a negedge with rst released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; mem_rdy = 1'b0; nzcv = 4'h0;
    set_instr(32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; mem_rdy = 1'b0; nzcv = 4'h0;
    set_instr(32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    #1;
    if ({retire_cnt, state, strb} !== {32'd0, 3'd0, S_IDLE}) begin
      $display("FAIL reset_initial got cnt=%0d st=%0d strb=%b exp cnt=0 st=0 strb=0", retire_cnt, state, strb);
      errors++;
    end
    checks++;
    // Reset during EXEC of ADD r1,r2,r3.
    @(negedge clk);
    rst = 1'b0; run = 1'b1; mem_rdy = 1'b1;
    set_instr(32'hE0821003, 1'b0, 1'b0, 1'b0, 4'd1);
    repeat (3) @(negedge clk);
    #1;
    if (state !== 3'd3) begin
      $display("FAIL reset_reach_exec got st=%0d exp st=3", state);
      errors++;
    end
    checks++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    if ({retire_cnt, state, strb} !== {32'd0, 3'd0, S_IDLE}) begin
      $display("FAIL reset_mid_exec got cnt=%0d st=%0d strb=%b exp cnt=0 st=0 strb=0", retire_cnt, state, strb);
      errors++;
    end
    checks++;
    // Reset while waiting on memory in FETCH.
    rst = 1'b0; mem_rdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    if ({state, strb} !== {3'd1, S_FW}) begin
      $display("FAIL reset_reach_fetch got st=%0d strb=%b exp st=1 strb=%b", state, strb, S_FW);
      errors++;
    end
    checks++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    if ({retire_cnt, state, strb} !== {32'd0, 3'd0, S_IDLE}) begin
      $display("FAIL reset_mid_fetch got cnt=%0d st=%0d strb=%b exp cnt=0 st=0 strb=0", retire_cnt, state, strb);
      errors++;
    end
    checks++;
  endtask

  task automatic test_normal();
    logic [12:0] exp [10];
    exp = '{{3'd0, S_IDLE}, {3'd1, S_FR}, {3'd2, S_DEC}, {3'd3, S_EX}, {3'd4, S_WB},
            {3'd1, S_FR}, {3'd2, S_DEC}, {3'd3, S_EX}, {3'd4, S_WB}, {3'd0, S_IDLE}};
    do_reset();
    mem_rdy = 1'b1; nzcv = 4'h0;
    set_instr(32'hE0821003, 1'b0, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 10; i++) begin
      run = (i != 8);
      #1;
      if ({state, strb} !== exp[i]) begin
        $display("FAIL normal cyc=%0d got st=%0d strb=%b exp st=%0d strb=%b", i, state, strb, exp[i][12:10], exp[i][9:0]);
        errors++;
      end
      checks++;
      if (i == 4 || i == 9) begin
        if (retire_cnt !== ((i == 4) ? 32'd1 : 32'd2)) begin
          $display("FAIL normal_retire cyc=%0d got %0d exp %0d", i, retire_cnt, (i == 4) ? 1 : 2);
          errors++;
        end
        checks++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_compare();
    logic [12:0] exp [8];
    exp = '{{3'd0, S_IDLE}, {3'd1, S_FR}, {3'd2, S_DEC}, {3'd3, S_EXF},
            {3'd1, S_FR}, {3'd2, S_DEC}, {3'd3, S_EXF}, {3'd0, S_IDLE}};
    do_reset();
    mem_rdy = 1'b1; nzcv = 4'h0;
    set_instr(32'hE3510000, 1'b0, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 8; i++) begin
      run = (i != 6);
      #1;
      if ({state, strb} !== exp[i]) begin
        $display("FAIL compare cyc=%0d got st=%0d strb=%b exp st=%0d strb=%b", i, state, strb, exp[i][12:10], exp[i][9:0]);
        errors++;
      end
      checks++;
      if (i == 4 || i == 7) begin
        if (retire_cnt !== ((i == 4) ? 32'd1 : 32'd2)) begin
          $display("FAIL compare_retire cyc=%0d got %0d exp %0d", i, retire_cnt, (i == 4) ? 1 : 2);
          errors++;
        end
        checks++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cond_fail();
    logic [12:0] exp [6];
    exp = '{{3'd0, S_IDLE}, {3'd1, S_FR}, {3'd2, S_DEC}, {3'd1, S_FR}, {3'd2, S_DEC}, {3'd0, S_IDLE}};
    do_reset();
    mem_rdy = 1'b1; nzcv = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      set_instr((i < 3) ? 32'h00821003 : 32'hF0821003, 1'b0, 1'b0, 1'b0, 4'd1);
      run = (i != 4);
      #1;
      if ({state, strb} !== exp[i]) begin
        $display("FAIL cond_fail cyc=%0d got st=%0d strb=%b exp st=%0d strb=%b", i, state, strb, exp[i][12:10], exp[i][9:0]);
        errors++;
      end
      checks++;
      @(negedge clk);
    end
    #1;
    if (retire_cnt !== 32'd0) begin
      $display("FAIL cond_fail_retire got %0d exp 0", retire_cnt);
      errors++;
    end
    checks++;
  endtask

  task automatic test_exc_return_memwait();
    logic [12:0] exp [9];
    exp = '{{3'd0, S_IDLE}, {3'd1, S_FW}, {3'd1, S_FW}, {3'd1, S_FW}, {3'd1, S_FR},
            {3'd2, S_DEC}, {3'd3, S_EXF}, {3'd4, S_WBPC}, {3'd0, S_IDLE}};
    do_reset();
    nzcv = 4'h0;
    set_instr(32'hE1B0F00E, 1'b0, 1'b0, 1'b1, 4'hF);
    for (int i = 0; i < 9; i++) begin
      mem_rdy = (i == 0) || (i >= 4);
      run = (i != 7);
      #1;
      if ({state, strb} !== exp[i]) begin
        $display("FAIL exc_ret cyc=%0d got st=%0d strb=%b exp st=%0d strb=%b", i, state, strb, exp[i][12:10], exp[i][9:0]);
        errors++;
      end
      checks++;
      @(negedge clk);
    end
    #1;
    if (retire_cnt !== 32'd1) begin
      $display("FAIL exc_ret_retire got %0d exp 1", retire_cnt);
      errors++;
    end
    checks++;
  endtask

  task automatic test_undef_trap();
    logic [12:0] exp [8];
    exp = '{{3'd0, S_IDLE}, {3'd1, S_FR}, {3'd2, S_DEC}, {3'd5, S_TRAP},
            {3'd5, S_TRAP}, {3'd5, S_TRAP}, {3'd5, S_TRAP}, {3'd0, S_IDLE}};
    do_reset();
    mem_rdy = 1'b1; nzcv = 4'b0000;
    // Condition EQ fails with Z=0, but undefined takes priority.
    set_instr(32'h07F000F0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      run = (i != 4);
      rst = (i >= 6);
      #1;
      if ({state, strb} !== exp[i]) begin
        $display("FAIL undef cyc=%0d got st=%0d strb=%b exp st=%0d strb=%b", i, state, strb, exp[i][12:10], exp[i][9:0]);
        errors++;
      end
      checks++;
      if (i == 5) begin
        if (retire_cnt !== 32'd0) begin
          $display("FAIL undef_retire got %0d exp 0", retire_cnt);
          errors++;
        end
        checks++;
      end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_run_drop();
    logic [12:0] exp [7];
    exp = '{{3'd0, S_IDLE}, {3'd1, S_FR}, {3'd2, S_DEC}, {3'd3, S_EX},
            {3'd4, S_WB}, {3'd0, S_IDLE}, {3'd0, S_IDLE}};
    do_reset();
    mem_rdy = 1'b1; nzcv = 4'h0;
    set_instr(32'hE0821003, 1'b0, 1'b0, 1'b0, 4'd1);
    for (int i = 0; i < 7; i++) begin
      run = (i < 3);
      #1;
      if ({state, strb} !== exp[i]) begin
        $display("FAIL run_drop cyc=%0d got st=%0d strb=%b exp st=%0d strb=%b", i, state, strb, exp[i][12:10], exp[i][9:0]);
        errors++;
      end
      checks++;
      @(negedge clk);
    end
    #1;
    if (retire_cnt !== 32'd1) begin
      $display("FAIL run_drop_retire got %0d exp 1", retire_cnt);
      errors++;
    end
    checks++;
  endtask

  // {cond, nzcv, pass}: pass leads DECODE to EXEC, fail (run=0) to IDLE.
  task automatic test_cond_table();
    logic [8:0] vec [24];
    vec = '{{4'h0, 4'b0100, 1'b1}, {4'h0, 4'b0000, 1'b0}, {4'h1, 4'b0100, 1'b0}, {4'h1, 4'b0000, 1'b1},
            {4'h2, 4'b0010, 1'b1}, {4'h3, 4'b0010, 1'b0}, {4'h4, 4'b1000, 1'b1}, {4'h5, 4'b1000, 1'b0},
            {4'h6, 4'b0001, 1'b1}, {4'h7, 4'b0000, 1'b1}, {4'h8, 4'b0010, 1'b1}, {4'h8, 4'b0110, 1'b0},
            {4'h9, 4'b0110, 1'b1}, {4'h9, 4'b0010, 1'b0}, {4'hA, 4'b1001, 1'b1}, {4'hA, 4'b1000, 1'b0},
            {4'hB, 4'b1000, 1'b1}, {4'hB, 4'b0000, 1'b0}, {4'hC, 4'b0000, 1'b1}, {4'hC, 4'b0100, 1'b0},
            {4'hC, 4'b1000, 1'b0}, {4'hD, 4'b0100, 1'b1}, {4'hD, 4'b1001, 1'b0}, {4'hE, 4'b0000, 1'b1}};
    for (int k = 0; k < 24; k++) begin
      do_reset();
      run = 1'b1; mem_rdy = 1'b1; nzcv = vec[k][4:1];
      set_instr({vec[k][8:5], 28'h0821003}, 1'b0, 1'b0, 1'b0, 4'd1);
      repeat (2) @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      #1;
      if (state !== (vec[k][0] ? 3'd3 : 3'd0)) begin
        $display("FAIL cond_table cond=%h nzcv=%b got st=%0d exp st=%0d", vec[k][8:5], vec[k][4:1], state, vec[k][0] ? 3 : 0);
        errors++;
      end
      checks++;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_rdy = 1'b0; nzcv = 4'h0;
    ir = 32'h0; und_ins = 1'b0; ttcc = 1'b0; s = 1'b0; rd = 4'h0;
    test_reset();
    test_normal();
    test_compare();
    test_cond_fail();
    test_exc_return_memwait();
    test_undef_trap();
    test_run_drop();
    test_cond_table();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_seq_ctrl.md
# dp_seq_ctrl

Multi-cycle sequencer for the data-processing datapath. It drives the shared instruction decoder, register file, barrel shifter/ALU and flag register through fetch, decode, execute and writeback. It also evaluates the instruction condition field, handles compare-class (TTCC) and PC-writing instructions, and halts on an undefined instruction. It sits between instruction memory and the datapath, consuming the decoder's classification outputs.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- run  in  1  run enable, sampled only at instruction boundaries
- mem_rdy  in  1  instruction memory data valid; qualified only in FETCH
- ir  in  32  instruction register contents, fed back to the decoder; cond = ir[31:28]
- und_ins  in  1  decoder: undefined instruction
- ttcc  in  1  decoder: TST/TEQ/CMP/CMN
- s  in  1  decoder: S bit
- rd  in  4  decoder: destination register
- nzcv  in  4  current flags {N,Z,C,V}
- mem_req  out  1  instruction fetch request
- ir_we  out  1  latch instruction
- pc_we  out  1  write PC
- pc_src  out  1  PC source: 0 = PC+4, 1 = ALU result
- rf_re  out  1  latch operand registers A/B/C
- alu_en  out  1  latch ALU/shifter result and new flags
- flag_we  out  1  commit NZCV
- rf_we  out  1  register-file write of rd
- und_trap  out  1  undefined-instruction halt indicator
- busy  out  1  high in any state except IDLE and TRAP
- state  out  3  current state encoding, for debug
- retire_cnt  out  32  count of executed (condition-passed) instructions

## Operation
- States are IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, TRAP=5. Codes 6 and 7 are illegal and go to IDLE on the next clock.
- **IDLE:** all strobes 0. If run=1, go to FETCH.
- **FETCH:** mem_req=1. While mem_rdy=0, stay in FETCH.
  - When mem_rdy=1: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
- **DECODE:** rf_re=1. Next state is chosen in priority order:
  1. und_ins=1 → TRAP.
  2. cond fails → instruction skipped; go to FETCH if run=1, else IDLE.
  3. Otherwise → EXEC.
- **Condition rules:**
  - EQ/NE test Z; CS/CC test C; MI/PL test N; VS/VC test V.
  - HI is C&!Z; LS is !C|Z.
  - GE is N==V; LT is N!=V.
  - GT is !Z&(N==V); LE is Z|(N!=V).
  - AL passes; NV (4'hF) never passes.
- **EXEC:** alu_en=1. flag_we = s|ttcc. retire_cnt increments.
  - If ttcc=1, go to FETCH when run=1, else IDLE.
  - Otherwise go to WB.
- **WB:**
  - If rd != 4'hF: rf_we=1.
  - If rd == 4'hF (exception return): pc_we=1, pc_src=1, rf_we=0.
  - Then go to FETCH when run=1, else IDLE.
- **TRAP:** und_trap=1, all other strobes 0. Absorbing; only rst leaves it.
- **Strobe decoding:**
  - Strobes are decoded combinationally from state and inputs.
  - Decoder inputs are sampled only in DECODE, EXEC and WB; they are don't-care elsewhere.
  - mem_rdy outside FETCH is ignored.
- **retire_cnt:** 32-bit and wraps 0xFFFFFFFF → 0. Skipped and trapped instructions are not counted.
- **run:** deasserting run never aborts an instruction. The current instruction completes and the FSM stops in IDLE at the boundary.

## Timing
- **Reset:**
  - rst=1 at a clock edge → state=IDLE, retire_cnt=0.
  - All outputs are 0 on the following cycle. This applies from any state, including mid-fetch and TRAP.
- **Cycle counts per instruction**, with mem_rdy high on the first FETCH cycle:
  - Writeback instruction: 4 cycles.
  - TTCC: 3 cycles.
  - Condition-failed: 2 cycles.
  - Undefined: 2 cycles, then TRAP.
- **Memory wait:** each mem_rdy=0 cycle in FETCH adds one cycle. mem_req stays high throughout.
- **Strobe widths:**
  - ir_we, rf_re, alu_en, flag_we and rf_we are single-cycle pulses per instruction.
  - pc_we pulses once in FETCH, plus once in WB for rd=15.
- **Back-to-back:** with run held high, the cycle after WB/EXEC/DECODE exit is FETCH. There is no idle bubble.
- **Counter update:** retire_cnt updates on the clock edge that ends EXEC.

## Structure
- **Package dp_ctrl_pkg:**
  - State enum (3-bit).
  - Condition-code localparams EQ..NV.
  - Flag bit positions N=3, Z=2, C=1, V=0.
- **Sub-module cond_check:** combinational; (cond[3:0], nzcv[3:0]) → pass. Instantiated once.
- **Main module:** state register, next-state logic, output decode and retire counter.

## Test plan
- **Reset:** run=1, mem_rdy=1, ir=ADD r1,r2,r3 (cond AL, E0821003), rst asserted mid-EXEC → next cycle state=0, all strobes 0, retire_cnt=0.
- **Normal stream:** ADD r1 (AL, s=0) with mem_rdy stuck high → FETCH/DECODE/EXEC/WB over 4 cycles; rf_we=1 in WB, flag_we=0; retire_cnt=1.
- **Compare:** CMP r1,#0 (E3510000, ttcc=1, s=1) → flag_we=1 in EXEC, no WB, next FETCH at cycle 4.
- **Condition fail:** nzcv=4'b0000 with ADDEQ (cond 0) → DECODE → FETCH, no alu_en/rf_we, retire_cnt unchanged. Repeat with cond 4'hF → same result.
- **Exception return and memory wait:** MOVS pc,lr (rd=15, s=1) → WB has pc_we=1, pc_src=1, rf_we=0. With mem_rdy low for 3 FETCH cycles → ir_we on cycle 4 only.
- **Undefined and run handling:** und_ins=1 in DECODE → TRAP with und_trap=1 held; run toggling has no effect; rst returns to IDLE. Separately, run dropped during EXEC → instruction completes, then IDLE.
